// File: rtl/m_store_buffer_pkg.sv
// Shared store-path encodings, byte-enable constants and the buffered entry layout.
package m_store_buffer_pkg;

  localparam logic [1:0] ST_SW   = 2'd0;
  localparam logic [1:0] ST_SH   = 2'd1;
  localparam logic [1:0] ST_SB   = 2'd2;
  localparam logic [1:0] ST_RSVD = 2'd3;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_LO_H  = 4'b0011;
  localparam logic [3:0] BE_HI_H  = 4'b1100;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] data;
  } stEntry_t;

  function automatic logic [31:0] wordAddr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/m_store_buffer_st_lane_align.sv
// Store lane alignment: op/addr[1:0]/data -> byte enables, lane-placed data, misalign flag.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module st_lane_align
  import m_store_buffer_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addrLo,
  input  logic [31:0] data,
  output logic [3:0]  byteen,
  output logic [31:0] alignedData,
  output logic        misalign
);

  always_comb begin
    byteen      = '0;
    alignedData = '0;
    misalign    = 1'b0;
    case (op)
      ST_SW: begin
        byteen      = BE_WORD;
        alignedData = data;
        misalign    = (addrLo != 2'b00);
      end
      ST_SH: begin
        byteen      = addrLo[1] ? BE_HI_H : BE_LO_H;
        alignedData = addrLo[1] ? {data[15:0], 16'h0000} : {16'h0000, data[15:0]};
        misalign    = addrLo[0];
      end
      ST_SB: begin
        byteen      = BE_BYTE0 << addrLo;
        // Replicate the byte into every lane, then keep only the enabled one.
        alignedData = {4{data[7:0]}} &
                      {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/m_store_buffer.sv
// M-stage store buffer: aligns sw/sh/sb, queues them FIFO, drains via mem_req/mem_ready.
// Latency: store accepted at edge N is presented on mem_* from cycle N+1 (no bypass).
// Backpressure: st_stall when full unless the head drains that cycle; STORE_ALIGN_CHECK_EN adds exc_ades.
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_stall,
  input  logic        ld_chk_valid,
  input  logic [31:0] ld_chk_addr,
  output logic        ld_hazard,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        buf_empty,
  output logic        exc_ades
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  stEntry_t         entries [DEPTH];
  logic [DEPTH-1:0] entryVld;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic [3:0]  alignBe;
  logic [31:0] alignData;
  logic        misalign;
  logic        storeOk;
  logic        enq;
  logic        deq;
  logic        headVld;
  logic        hitAny;
  logic        unusedBits;

  st_lane_align uAlign (
    .op          (st_op),
    .addrLo      (st_addr[1:0]),
    .data        (st_data),
    .byteen      (alignBe),
    .alignedData (alignData),
    .misalign    (misalign)
  );

`ifdef STORE_ALIGN_CHECK_EN
  // A misaligned store raises the exception and is dropped, not stalled.
  assign exc_ades   = st_valid && (st_op != ST_RSVD) && misalign;
  assign unusedBits = ^ld_chk_addr[1:0];
`else
  assign exc_ades   = 1'b0;
  assign unusedBits = ^{ld_chk_addr[1:0], misalign};
`endif

  assign headVld  = entryVld[head];
  assign storeOk  = st_valid && (st_op != ST_RSVD) && !exc_ades;
  assign deq      = headVld && mem_ready;
  assign enq      = storeOk && ((count != CNT_FULL) || deq);
  assign st_stall = storeOk && !enq;

  // Entry payload is not reset; outputs are gated by the head valid bit instead.
  assign mem_req    = headVld;
  assign mem_addr   = headVld ? wordAddr(entries[head].addr) : '0;
  assign mem_byteen = headVld ? entries[head].byteen : '0;
  assign mem_wdata  = headVld ? entries[head].data : '0;
  assign buf_empty  = (count == '0);

  always_comb begin
    hitAny = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryVld[i] && (entries[i].addr[31:2] == ld_chk_addr[31:2])) begin
        hitAny = 1'b1;
      end
    end
  end

  assign ld_hazard = ld_chk_valid && hitAny;

  always_ff @(posedge clk) begin
    if (enq) begin
      entries[tail] <= '{addr: st_addr, byteen: alignBe, data: alignData};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entryVld <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      // When full with simultaneous drain, head==tail and the enqueue write wins.
      if (deq) begin
        entryVld[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (enq) begin
        entryVld[tail] <= 1'b1;
        tail           <= tail + 1'b1;
      end
      if (enq && !deq) begin
        count <= count + 1'b1;
      end else if (!enq && deq) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
